unidade_controle: RTL and testbench
===================================

Name: unidade_controle

Overview:
- Multi-cycle control FSM for the 16-bit datapath.
- Latches one instruction word, sequences it over 1–3 execute steps, and drives:
  - the bus multiplexer select;
  - the register-file write enables;
  - the ALU operand/result latch enables;
  - the sign-extended immediate presented on the mux `imm` input.
- Sits directly upstream of the bus multiplexer and the register/ALU latches.

Parameters:
- LARGURA, 16, datapath and instruction width.
- LARGURA_IMM, 9, immediate field width, sign-extended to LARGURA.

Ports:
- clock  input  1  system clock, all state changes on rising edge
- reset  input  1  synchronous, active-high reset
- run  input  1  start request; sampled only in IDLE
- din  input  16  instruction word, captured when run is accepted
- ocupado  output  1  high in any state other than IDLE
- sel  output  4  bus mux select: 0000–0111 = r0–r7, 1000 = imm, 1001 = R (ALU result latch), 1111 = idle/zero
- imm  output  16  sign-extended IR[8:0]
- r_in  output  8  one-hot register write enable, bit n writes rn from bus
- a_in  output  1  load ALU operand A from bus
- g_in  output  1  load ALU result latch R
- alu_op  output  2  00 add, 01 sub, 10 and, 11 unused
- done  output  1  one-cycle pulse in the final step of an instruction
- erro  output  1  one-cycle pulse with done when the opcode is illegal

Behaviour:
- Instruction format:
  - opcode = IR[15:12]
  - rx = IR[11:9]
  - ry = IR[8:6]
  - imm field = IR[8:0]
- Opcodes:
  - 0000 mv rx,ry
  - 0001 mvi rx,#imm
  - 0010 add rx,ry
  - 0011 sub rx,ry
  - 0100 and rx,ry
  - all others illegal
- States: IDLE, T1, T2, T3. The state register and IR are the only storage; all outputs decode combinationally from state and IR.
- Reset (synchronous, checked before all else):
  - state = IDLE, IR = 0.
  - Outputs while in IDLE: sel = 1111, r_in = 0, a_in = g_in = done = erro = ocupado = 0, alu_op = 00, imm = 0 (IR = 0).
  - Reset asserted mid-instruction aborts it at the next edge; no done pulse, no further r_in.
- IDLE:
  - If run = 1 at the edge: IR <= din, go to T1. Otherwise stay.
  - din is ignored when run = 0.
- T1:
  - mv: sel = {0,ry}, r_in[rx] = 1, done = 1 -> IDLE.
  - mvi: sel = 1000, r_in[rx] = 1, done = 1 -> IDLE.
  - add/sub/and: sel = {0,rx}, a_in = 1 -> T2.
  - illegal: no enables, done = 1, erro = 1 -> IDLE.
- T2 (ALU ops only): sel = {0,ry}, g_in = 1, alu_op per opcode -> T3.
- T3: sel = 1001, r_in[rx] = 1, done = 1 -> IDLE.
- alu_op:
  - Driven with the opcode value only in T2; 00 otherwise.
  - Held stable across the whole T2 cycle.
- run is ignored while ocupado = 1; IR is not disturbed during an instruction.
- Back-to-back issue:
  - run high in the cycle after done (state back in IDLE) is accepted.
  - No bubble beyond that IDLE cycle.
- Latency from the run-accept edge to done: 1 cycle for mv/mvi/illegal, 3 cycles for ALU ops.
- Exactly one r_in bit is high in a write step; r_in is all-zero in every other step.
- rx == ry is legal and needs no special handling (e.g. add r3,r3 doubles r3).
- imm sign extension: IR[8] replicated into imm[15:9].

Test Plan:
- Reset then idle:
  - reset = 1 for 2 cycles, run = 0 -> sel = 1111, r_in = 0, ocupado = 0, done = 0.
  - Outputs unchanged for 5 idle cycles.
- mvi r2,#-3:
  - din = 0x15FD, run pulse.
  - T1: sel = 1000, imm = 0xFFFD, r_in = 00000100, done = 1.
  - Next cycle ocupado = 0.
- add r1,r5 (din = 0x2340):
  - T1: sel = 0001, a_in = 1.
  - T2: sel = 0101, g_in = 1, alu_op = 00.
  - T3: sel = 1001, r_in = 00000010, done = 1.
- sub r0,r0 (din = 0x3000) with run held high throughout -> T1/T2/T3 sequence as above with alu_op = 01 in T2.
  - IR unchanged despite din toggling.
  - A second instruction is accepted only in the IDLE cycle after done.
- Illegal opcode 0xF000 -> one cycle later done = 1, erro = 1, r_in = 0, a_in = g_in = 0, then IDLE.
- Reset asserted in T2 of and r4,r6 (din = 0x4980) -> next cycle state IDLE, sel = 1111, no r_in pulse, no done.

Source files
------------

// File: rtl/unidade_controle.sv
// Multi-cycle control FSM for the 16-bit datapath: latches one instruction
// and sequences bus select, register/ALU latch enables and the immediate.
module unidade_controle #(
  parameter int LARGURA     = 16,
  parameter int LARGURA_IMM = 9
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               run,
  input  logic [LARGURA-1:0] din,
  output logic               ocupado,
  output logic [3:0]         sel,
  output logic [LARGURA-1:0] imm,
  output logic [7:0]         r_in,
  output logic               a_in,
  output logic               g_in,
  output logic [1:0]         alu_op,
  output logic               done,
  output logic               erro,
  output logic [1:0]         estado
);

  // Handshake: run is sampled only while ocupado = 0 (IDLE); the edge that
  // sees run = 1 there captures din into IR. done pulses in the last step,
  // and run may be raised again in the very next (IDLE) cycle.

  typedef enum logic [1:0] {IDLE, T1, T2, T3} estado_t;

  localparam logic [3:0] OP_MV  = 4'b0000;
  localparam logic [3:0] OP_MVI = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0011;
  localparam logic [3:0] OP_AND = 4'b0100;

  localparam logic [3:0] SEL_IMM  = 4'b1000;
  localparam logic [3:0] SEL_R    = 4'b1001;
  localparam logic [3:0] SEL_NADA = 4'b1111;

  estado_t            state, next_state;
  logic [LARGURA-1:0] ir;
  logic [3:0]         opcode;
  logic [2:0]         rx, ry;

  assign opcode = ir[LARGURA-1 -: 4];
  assign rx     = ir[LARGURA-5 -: 3];
  assign ry     = ir[LARGURA-8 -: 3];
  assign imm    = {{(LARGURA-LARGURA_IMM){ir[LARGURA_IMM-1]}}, ir[LARGURA_IMM-1:0]};
  assign estado = state;

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      ir    <= '0;
    end else begin
      state <= next_state;
      if (state == IDLE && run) ir <= din;
    end
  end

  always_comb begin
    next_state = state;
    ocupado    = 1'b1;
    sel        = SEL_NADA;
    r_in       = '0;
    a_in       = 1'b0;
    g_in       = 1'b0;
    alu_op     = 2'b00;
    done       = 1'b0;
    erro       = 1'b0;
    case (state)
      IDLE: begin
        ocupado = 1'b0;
        if (run) next_state = T1;
      end
      T1: begin
        case (opcode)
          OP_MV: begin
            sel        = {1'b0, ry};
            r_in       = 8'b1 << rx;
            done       = 1'b1;
            next_state = IDLE;
          end
          OP_MVI: begin
            sel        = SEL_IMM;
            r_in       = 8'b1 << rx;
            done       = 1'b1;
            next_state = IDLE;
          end
          OP_ADD, OP_SUB, OP_AND: begin
            sel        = {1'b0, rx};
            a_in       = 1'b1;
            next_state = T2;
          end
          default: begin
            done       = 1'b1;
            erro       = 1'b1;
            next_state = IDLE;
          end
        endcase
      end
      T2: begin
        sel  = {1'b0, ry};
        g_in = 1'b1;
        case (opcode)
          OP_SUB:  alu_op = 2'b01;
          OP_AND:  alu_op = 2'b10;
          default: alu_op = 2'b00;
        endcase
        next_state = T3;
      end
      T3: begin
        sel        = SEL_R;
        r_in       = 8'b1 << rx;
        done       = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

endmodule

// File: tb/tb_unidade_controle.sv
// Bench for unidade_controle: per-scenario tasks queue stimulus and expected
// output vectors, then replay them cycle by cycle comparing at the falling edge.
module tb_unidade_controle;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        run   = 1'b0;
  logic [15:0] din   = '0;
  logic        ocupado, a_in, g_in, done, erro;
  logic [3:0]  sel;
  logic [15:0] imm;
  logic [7:0]  r_in;
  logic [1:0]  alu_op, estado;

  unidade_controle dut (
    .clock(clock), .reset(reset), .run(run), .din(din),
    .ocupado(ocupado), .sel(sel), .imm(imm), .r_in(r_in),
    .a_in(a_in), .g_in(g_in), .alu_op(alu_op), .done(done),
    .erro(erro), .estado(estado)
  );

  always #5 clock = ~clock;

  // {ocupado, sel, imm, r_in, a_in, g_in, alu_op, done, erro}
  logic [34:0] obs;
  assign obs = {ocupado, sel, imm, r_in, a_in, g_in, alu_op, done, erro};

  logic        rst_q[$];
  logic        run_q[$];
  logic [15:0] din_q[$];
  logic [34:0] exp_q[$];
  logic [34:0] exp_v;
  int compared   = 0;
  int mismatched = 0;

  function automatic logic [34:0] pk(input logic oc, input logic [3:0] s,
                                     input logic [15:0] im, input logic [7:0] r,
                                     input logic a, input logic g,
                                     input logic [1:0] op, input logic d,
                                     input logic e);
    return {oc, s, im, r, a, g, op, d, e};
  endfunction

  function automatic logic [15:0] sext(input logic [15:0] w);
    return {{7{w[8]}}, w[8:0]};
  endfunction

  // Inputs applied before an edge, with the outputs expected after it.
  task automatic drive(input logic rs, input logic rn, input logic [15:0] d,
                       input logic [34:0] e);
    rst_q.push_back(rs);
    run_q.push_back(rn);
    din_q.push_back(d);
    exp_q.push_back(e);
  endtask

  task automatic test_reset;
    drive(1, 0, 16'($urandom), pk(0, 4'hF, 16'h0, 8'h0, 0, 0, 2'b00, 0, 0));
    drive(1, 0, 16'($urandom), pk(0, 4'hF, 16'h0, 8'h0, 0, 0, 2'b00, 0, 0));
    for (int i = 0; i < 5; i++)
      drive(0, 0, 16'($urandom), pk(0, 4'hF, 16'h0, 8'h0, 0, 0, 2'b00, 0, 0));
    while (exp_q.size() > 0) begin
      reset = rst_q.pop_front(); run = run_q.pop_front(); din = din_q.pop_front();
      @(posedge clock); @(negedge clock);
      exp_v = exp_q.pop_front();
      compared++;
      if (obs !== exp_v) begin
        mismatched++;
        $display("FAIL test_reset: got %h expected %h", obs, exp_v);
      end
    end
  endtask

  task automatic test_mvi;
    drive(0, 1, 16'h15FD, pk(1, 4'h8, 16'hFFFD, 8'b0000_0100, 0, 0, 2'b00, 1, 0));
    drive(0, 0, 16'h0000, pk(0, 4'hF, 16'hFFFD, 8'h0, 0, 0, 2'b00, 0, 0));
    while (exp_q.size() > 0) begin
      reset = rst_q.pop_front(); run = run_q.pop_front(); din = din_q.pop_front();
      @(posedge clock); @(negedge clock);
      exp_v = exp_q.pop_front();
      compared++;
      if (obs !== exp_v) begin
        mismatched++;
        $display("FAIL test_mvi: got %h expected %h", obs, exp_v);
      end
    end
  endtask

  task automatic test_add;
    drive(0, 1, 16'h2340, pk(1, 4'h1, 16'hFF40, 8'h0, 1, 0, 2'b00, 0, 0));
    drive(0, 0, 16'h0000, pk(1, 4'h5, 16'hFF40, 8'h0, 0, 1, 2'b00, 0, 0));
    drive(0, 0, 16'h0000, pk(1, 4'h9, 16'hFF40, 8'b0000_0010, 0, 0, 2'b00, 1, 0));
    drive(0, 0, 16'h0000, pk(0, 4'hF, 16'hFF40, 8'h0, 0, 0, 2'b00, 0, 0));
    while (exp_q.size() > 0) begin
      reset = rst_q.pop_front(); run = run_q.pop_front(); din = din_q.pop_front();
      @(posedge clock); @(negedge clock);
      exp_v = exp_q.pop_front();
      compared++;
      if (obs !== exp_v) begin
        mismatched++;
        $display("FAIL test_add: got %h expected %h", obs, exp_v);
      end
    end
  endtask

  // run stays high: later din values must not reach IR until the IDLE cycle.
  task automatic test_back_to_back;
    drive(0, 1, 16'h3000, pk(1, 4'h0, 16'h0000, 8'h0, 1, 0, 2'b00, 0, 0));
    drive(0, 1, 16'hA5C3, pk(1, 4'h0, 16'h0000, 8'h0, 0, 1, 2'b01, 0, 0));
    drive(0, 1, 16'h5A7E, pk(1, 4'h9, 16'h0000, 8'b0000_0001, 0, 0, 2'b00, 1, 0));
    drive(0, 1, 16'h1FFF, pk(0, 4'hF, 16'h0000, 8'h0, 0, 0, 2'b00, 0, 0));
    drive(0, 1, 16'h0EC0, pk(1, 4'h3, 16'h00C0, 8'b1000_0000, 0, 0, 2'b00, 1, 0));
    drive(0, 0, 16'h0000, pk(0, 4'hF, 16'h00C0, 8'h0, 0, 0, 2'b00, 0, 0));
    while (exp_q.size() > 0) begin
      reset = rst_q.pop_front(); run = run_q.pop_front(); din = din_q.pop_front();
      @(posedge clock); @(negedge clock);
      exp_v = exp_q.pop_front();
      compared++;
      if (obs !== exp_v) begin
        mismatched++;
        $display("FAIL test_back_to_back: got %h expected %h", obs, exp_v);
      end
    end
  endtask

  task automatic test_illegal;
    drive(0, 1, 16'hF000, pk(1, 4'hF, 16'h0000, 8'h0, 0, 0, 2'b00, 1, 1));
    drive(0, 0, 16'h0000, pk(0, 4'hF, 16'h0000, 8'h0, 0, 0, 2'b00, 0, 0));
    while (exp_q.size() > 0) begin
      reset = rst_q.pop_front(); run = run_q.pop_front(); din = din_q.pop_front();
      @(posedge clock); @(negedge clock);
      exp_v = exp_q.pop_front();
      compared++;
      if (obs !== exp_v) begin
        mismatched++;
        $display("FAIL test_illegal: got %h expected %h", obs, exp_v);
      end
    end
  endtask

  task automatic test_reset_mid;
    drive(0, 1, 16'h4980, pk(1, 4'h4, 16'hFF80, 8'h0, 1, 0, 2'b00, 0, 0));
    drive(0, 0, 16'h0000, pk(1, 4'h6, 16'hFF80, 8'h0, 0, 1, 2'b10, 0, 0));
    drive(1, 0, 16'h0000, pk(0, 4'hF, 16'h0000, 8'h0, 0, 0, 2'b00, 0, 0));
    drive(0, 0, 16'h0000, pk(0, 4'hF, 16'h0000, 8'h0, 0, 0, 2'b00, 0, 0));
    while (exp_q.size() > 0) begin
      reset = rst_q.pop_front(); run = run_q.pop_front(); din = din_q.pop_front();
      @(posedge clock); @(negedge clock);
      exp_v = exp_q.pop_front();
      compared++;
      if (obs !== exp_v) begin
        mismatched++;
        $display("FAIL test_reset_mid: got %h expected %h", obs, exp_v);
      end
    end
  endtask

  // Random instruction stream, back-to-back, with random run/din while busy.
  task automatic test_random_stream;
    logic [15:0] w;
    logic [3:0]  op;
    logic [7:0]  onehot;
    for (int n = 0; n < 40; n++) begin
      op = ($urandom_range(0, 5) == 5) ? 4'($urandom_range(5, 15)) : 4'($urandom_range(0, 4));
      w  = {op, 12'($urandom)};
      onehot = 8'h0;
      onehot[w[11:9]] = 1'b1;
      case (op)
        4'b0000: drive(0, 1, w, pk(1, {1'b0, w[8:6]}, sext(w), onehot, 0, 0, 2'b00, 1, 0));
        4'b0001: drive(0, 1, w, pk(1, 4'h8, sext(w), onehot, 0, 0, 2'b00, 1, 0));
        4'b0010, 4'b0011, 4'b0100: begin
          drive(0, 1, w, pk(1, {1'b0, w[11:9]}, sext(w), 8'h0, 1, 0, 2'b00, 0, 0));
          drive(0, 1'($urandom), 16'($urandom),
                pk(1, {1'b0, w[8:6]}, sext(w), 8'h0, 0, 1,
                   (op == 4'b0011) ? 2'b01 : (op == 4'b0100) ? 2'b10 : 2'b00, 0, 0));
          drive(0, 1'($urandom), 16'($urandom), pk(1, 4'h9, sext(w), onehot, 0, 0, 2'b00, 1, 0));
        end
        default: drive(0, 1, w, pk(1, 4'hF, sext(w), 8'h0, 0, 0, 2'b00, 1, 1));
      endcase
      drive(0, 1'($urandom), 16'($urandom), pk(0, 4'hF, sext(w), 8'h0, 0, 0, 2'b00, 0, 0));
    end
    while (exp_q.size() > 0) begin
      reset = rst_q.pop_front(); run = run_q.pop_front(); din = din_q.pop_front();
      @(posedge clock); @(negedge clock);
      exp_v = exp_q.pop_front();
      compared++;
      if (obs !== exp_v) begin
        mismatched++;
        $display("FAIL test_random_stream: got %h expected %h", obs, exp_v);
      end
    end
  endtask

  initial begin
    test_reset();
    test_mvi();
    test_add();
    test_back_to_back();
    test_illegal();
    test_reset_mid();
    test_random_stream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
